// File: rtl/localization_pkg.sv
// Shared definitions for the direction synthesis path.
//   - ATAN_TABLE        : CORDIC arctangent table, Q3.13 radians, index = micro-rotation
//   - CORDIC_GAIN_INIT  : 1/K pre-scale so the rotated vector lands at 1.0 (Q2.14)
//   - PI_Q13 / HALF_PI_Q13 : quadrant folding constants, Q3.13
//   - state_t           : top-level sequencing states
//   - sat16             : 18-bit signed to 16-bit signed saturation
//   - dither_word       : adds signed LFSR nibbles to a {y, x} vector with saturation
package localization_pkg;

    localparam logic signed [15:0] ATAN_TABLE [0:15] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
        16'sd511,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd0,    16'sd0
    };

    localparam logic signed [17:0] CORDIC_GAIN_INIT = 18'sd9949;
    localparam logic signed [15:0] PI_Q13           = 16'sd25736;
    localparam logic signed [15:0] HALF_PI_Q13      = 16'sd12868;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        EMIT
    } state_t;

    // Out of range whenever the three top bits disagree.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v[17:15] == 3'b000 || v[17:15] == 3'b111)
            return v[15:0];
        else if (v[17])
            return 16'sh8000;
        else
            return 16'sh7FFF;
    endfunction

    function automatic logic [31:0] dither_word(input logic signed [15:0] x,
                                                input logic signed [15:0] y,
                                                input logic [15:0] lfsr);
        logic signed [17:0] xs;
        logic signed [17:0] ys;
        xs = {{2{x[15]}}, x} + {{14{lfsr[3]}}, lfsr[3:0]};
        ys = {{2{y[15]}}, y} + {{14{lfsr[7]}}, lfsr[7:4]};
        return {sat16(ys), sat16(xs)};
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q3.13 angle in Q2.14.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset (aborts any rotation)
//   start_in       : load angle_in and begin (pre-rotation applied at load)
//   angle_in       : signed Q3.13 radians, any value
//   done_out       : high for one cycle when x_out/y_out hold the final result
//   x_out, y_out   : cos/sin, saturated signed Q2.14
module cordic_rotator
    import localization_pkg::*;
#(
    parameter int unsigned ITERATIONS = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic signed [15:0] angle_in,
    output logic               done_out,
    output logic signed [15:0] x_out,
    output logic signed [15:0] y_out
);

    logic               busy;
    logic [4:0]         iter;
    logic signed [17:0] x_q;
    logic signed [17:0] y_q;
    logic signed [15:0] z_q;
    logic               negate_q;

    logic signed [17:0] x_shift;
    logic signed [17:0] y_shift;
    logic signed [17:0] x_fin;
    logic signed [17:0] y_fin;
    logic signed [15:0] atan_i;

    always_comb begin
        x_shift = x_q >>> iter;
        y_shift = y_q >>> iter;
        atan_i  = ATAN_TABLE[iter[3:0]];
        x_fin   = negate_q ? -x_q : x_q;
        y_fin   = negate_q ? -y_q : y_q;
        x_out   = sat16(x_fin);
        y_out   = sat16(y_fin);
    end

    // Result is read combinationally in the cycle after the last micro-rotation.
    assign done_out = busy && (iter == 5'(ITERATIONS));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy     <= 1'b0;
            iter     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            negate_q <= 1'b0;
        end else if (start_in) begin
            busy <= 1'b1;
            iter <= '0;
            x_q  <= CORDIC_GAIN_INIT;
            y_q  <= '0;
            // Fold outer quadrants onto the convergence range; rotating by pi
            // is a negation of the final vector.
            if (angle_in > HALF_PI_Q13) begin
                z_q      <= angle_in - PI_Q13;
                negate_q <= 1'b1;
            end else if (angle_in < -HALF_PI_Q13) begin
                z_q      <= angle_in + PI_Q13;
                negate_q <= 1'b1;
            end else begin
                z_q      <= angle_in;
                negate_q <= 1'b0;
            end
        end else if (busy) begin
            if (iter == 5'(ITERATIONS)) begin
                busy <= 1'b0;
            end else begin
                if (!z_q[15]) begin
                    x_q <= x_q - y_shift;
                    y_q <= y_q + x_shift;
                    z_q <= z_q - atan_i;
                end else begin
                    x_q <= x_q + y_shift;
                    y_q <= y_q - x_shift;
                    z_q <= z_q + atan_i;
                end
                iter <= iter + 5'd1;
            end
        end
    end

endmodule

// File: rtl/direction_synthesizer.sv
// Turns one angle into QUANTITY identical {y, x} unit direction beats on a
// valid/ready stream.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   angle_in              : signed Q3.13 radians (modulo 2*pi)
//   angle_valid_in        : angle handshake valid
//   angle_ready_out       : high only while idle
//   direction_out         : {y[31:16], x[15:0]}, signed Q2.14
//   direction_valid_out   : direction_out valid
//   direction_ready_in    : downstream accepts beat
//   direction_last_out    : marks beat QUANTITY-1
// Build option: define DIRECTION_SYNTH_DITHER_EN to add per-beat LFSR dither.
module direction_synthesizer
    import localization_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned QUANTITY   = 512,
    parameter int unsigned ITERATIONS = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic signed [15:0]    angle_in,
    input  logic                  angle_valid_in,
    output logic                  angle_ready_out,
    output logic [DATA_WIDTH-1:0] direction_out,
    output logic                  direction_valid_out,
    input  logic                  direction_ready_in,
    output logic                  direction_last_out
);

    localparam int unsigned CNT_W = $clog2(QUANTITY) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QUANTITY - 1);

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic               rot_start;
    logic               rot_done;
    logic signed [15:0] rot_x;
    logic signed [15:0] rot_y;

    assign rot_start = angle_valid_in && angle_ready_out;

    cordic_rotator #(
        .ITERATIONS(ITERATIONS)
    ) u_rotator (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start_in(rot_start),
        .angle_in(angle_in),
        .done_out(rot_done),
        .x_out   (rot_x),
        .y_out   (rot_y)
    );

`ifdef DIRECTION_SYNTH_DITHER_EN
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic signed [15:0] base_x;
    logic signed [15:0] base_y;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            angle_ready_out     <= 1'b1;
            direction_out       <= '0;
            direction_valid_out <= 1'b0;
            direction_last_out  <= 1'b0;
            beat_cnt            <= '0;
`ifdef DIRECTION_SYNTH_DITHER_EN
            lfsr                <= 16'hACE1;
            base_x              <= '0;
            base_y              <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rot_start) begin
                        state           <= ROTATE;
                        angle_ready_out <= 1'b0;
                    end
                end
                ROTATE: begin
                    if (rot_done) begin
                        state               <= EMIT;
                        direction_valid_out <= 1'b1;
                        direction_last_out  <= (QUANTITY == 1);
                        beat_cnt            <= '0;
`ifdef DIRECTION_SYNTH_DITHER_EN
                        base_x              <= rot_x;
                        base_y              <= rot_y;
                        direction_out       <= DATA_WIDTH'(dither_word(rot_x, rot_y, lfsr));
`else
                        direction_out       <= DATA_WIDTH'({rot_y, rot_x});
`endif
                    end
                end
                EMIT: begin
                    if (direction_ready_in) begin
`ifdef DIRECTION_SYNTH_DITHER_EN
                        lfsr <= lfsr_next;
`endif
                        if (beat_cnt == LAST_CNT) begin
                            state               <= IDLE;
                            direction_valid_out <= 1'b0;
                            direction_last_out  <= 1'b0;
                            angle_ready_out     <= 1'b1;
                            beat_cnt            <= '0;
                        end else begin
                            beat_cnt           <= beat_cnt + CNT_W'(1);
                            direction_last_out <= (beat_cnt + CNT_W'(1) == LAST_CNT);
`ifdef DIRECTION_SYNTH_DITHER_EN
                            // Next beat's word is prepared from the advanced LFSR.
                            direction_out <= DATA_WIDTH'(dither_word(base_x, base_y, lfsr_next));
`endif
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    angle_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_direction_synthesizer.sv
module tb_direction_synthesizer;

    localparam int unsigned Q = 512;
`ifdef DIRECTION_SYNTH_DITHER_EN
    localparam int TOL = 16;
`else
    localparam int TOL = 8;
`endif

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic signed [15:0] angle_in;
    logic               angle_valid_in;
    logic               angle_ready_out;
    logic [31:0]        direction_out;
    logic               direction_valid_out;
    logic               direction_ready_in;
    logic               direction_last_out;

    logic signed [15:0] angle1;
    logic               angle_valid1;
    logic               angle_ready1;
    logic [31:0]        direction1;
    logic               direction_valid1;
    logic               direction_ready1;
    logic               direction_last1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_in = ~clk_in;

    direction_synthesizer #(
        .DATA_WIDTH(32),
        .QUANTITY  (Q),
        .ITERATIONS(16)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .angle_in           (angle_in),
        .angle_valid_in     (angle_valid_in),
        .angle_ready_out    (angle_ready_out),
        .direction_out      (direction_out),
        .direction_valid_out(direction_valid_out),
        .direction_ready_in (direction_ready_in),
        .direction_last_out (direction_last_out)
    );

    direction_synthesizer #(
        .DATA_WIDTH(32),
        .QUANTITY  (1),
        .ITERATIONS(16)
    ) dut_q1 (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .angle_in           (angle1),
        .angle_valid_in     (angle_valid1),
        .angle_ready_out    (angle_ready1),
        .direction_out      (direction1),
        .direction_valid_out(direction_valid1),
        .direction_ready_in (direction_ready1),
        .direction_last_out (direction_last1)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int xof(input logic [31:0] w);
        logic signed [15:0] h;
        h = w[15:0];
        return int'(h);
    endfunction

    function automatic int yof(input logic [31:0] w);
        logic signed [15:0] h;
        h = w[31:16];
        return int'(h);
    endfunction

    // Present one angle; returns at the negedge just after the accepting edge.
    task automatic send_angle(input logic signed [15:0] a);
        @(negedge clk_in);
        angle_in       = a;
        angle_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        angle_valid_in = 1'b0;
    endtask

    // Counts clock edges from accept until direction_valid_out is seen.
    task automatic wait_first_valid(output int cyc);
        cyc = 0;
        while (!direction_valid_out && cyc < 100) begin
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
    endtask

    // Consumes a full burst, starting at the negedge where the first valid is visible.
    task automatic drain(input bit random_ready, input bit pulse_angle,
                         input int ex, input int ey,
                         output int beats, output int bad_last, output int bad_tol,
                         output int bad_same, output int bad_stable, output int n_diff,
                         output logic [31:0] first_word);
        int          guard;
        bit          prev_stall;
        logic [31:0] prev_word;
        logic [31:0] prev_hs;
        logic        rdy;
        beats = 0; bad_last = 0; bad_tol = 0; bad_same = 0; bad_stable = 0; n_diff = 0;
        guard = 0; prev_stall = 1'b0; prev_word = '0; prev_hs = '0; first_word = '0;
        while (beats < Q && guard < 5000) begin
            if (guard > 0) @(negedge clk_in);
            guard++;
            if (prev_stall && direction_out !== prev_word) bad_stable++;
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            direction_ready_in = rdy;
            if (pulse_angle) begin
                angle_valid_in = 1'($urandom_range(0, 1));
                angle_in       = 16'sd12868;
            end
            if (direction_valid_out) begin
                if (beats == 0) first_word = direction_out;
                if (rdy) begin
                    if (direction_last_out !== (beats == int'(Q) - 1)) bad_last++;
                    if (iabs(xof(direction_out) - ex) > TOL ||
                        iabs(yof(direction_out) - ey) > TOL) bad_tol++;
                    if (direction_out !== first_word) bad_same++;
                    if (beats > 0 && direction_out !== prev_hs) n_diff++;
                    prev_hs = direction_out;
                    beats++;
                end
                prev_stall = !rdy;
                prev_word  = direction_out;
            end else begin
                prev_stall = 1'b0;
            end
        end
        angle_valid_in     = 1'b0;
        direction_ready_in = 1'b1;
    endtask

    task automatic check_burst(input string tag, input int beats, input int bad_last,
                               input int bad_tol, input int bad_same);
        compared++;
        if (beats != int'(Q)) begin
            mismatched++;
            $display("FAIL %s beats: got %0d want %0d", tag, beats, Q);
        end
        compared++;
        if (bad_last != 0) begin
            mismatched++;
            $display("FAIL %s last_position: got %0d wrong beats want 0", tag, bad_last);
        end
        compared++;
        if (bad_tol != 0) begin
            mismatched++;
            $display("FAIL %s tolerance: got %0d beats out of range want 0", tag, bad_tol);
        end
`ifndef DIRECTION_SYNTH_DITHER_EN
        compared++;
        if (bad_same != 0) begin
            mismatched++;
            $display("FAIL %s identical_beats: got %0d differing want 0", tag, bad_same);
        end
`endif
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        angle_valid_in = 1'b1; angle_in = 16'sd100;
        angle_valid1 = 1'b0; angle1 = '0;
        direction_ready_in = 1'b1; direction_ready1 = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        angle_valid_in = 1'b0;
        compared++;
        if (angle_ready_out !== 1'b1) begin
            mismatched++; $display("FAIL reset_ready: got %b want 1", angle_ready_out);
        end
        compared++;
        if (direction_valid_out !== 1'b0 || direction_last_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid_last: got %b%b want 00", direction_valid_out, direction_last_out);
        end
        compared++;
        if (direction_out !== 32'h0) begin
            mismatched++; $display("FAIL reset_direction: got %h want 00000000", direction_out);
        end
        compared++;
        if (angle_ready1 !== 1'b1 || direction_valid1 !== 1'b0 || direction_last1 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_q1: got ready/valid/last %b%b%b want 100",
                     angle_ready1, direction_valid1, direction_last1);
        end
    endtask

    task automatic test_angle_zero;
        int cyc, beats, bl, bt, bs, bst, nd;
        logic [31:0] fw;
        send_angle(16'sd0);
        compared++;
        if (angle_ready_out !== 1'b0) begin
            mismatched++; $display("FAIL busy_ready: got %b want 0", angle_ready_out);
        end
        wait_first_valid(cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++; $display("FAIL latency: got %0d cycles want 17", cyc);
        end
        drain(1'b0, 1'b0, 16384, 0, beats, bl, bt, bs, bst, nd, fw);
        check_burst("angle0", beats, bl, bt, bs);
        @(negedge clk_in);
        compared++;
        if (angle_ready_out !== 1'b1 || direction_valid_out !== 1'b0) begin
            mismatched++;
            $display("FAIL angle0_return_idle: got ready/valid %b%b want 10",
                     angle_ready_out, direction_valid_out);
        end
`ifdef DIRECTION_SYNTH_DITHER_EN
        compared++;
        if (nd < int'(Q) / 2) begin
            mismatched++; $display("FAIL dither_changes: got %0d changes want >= %0d", nd, Q / 2);
        end
`endif
    endtask

    typedef struct {
        logic signed [15:0] a;
        int ex;
        int ey;
    } vec_t;

    task automatic test_angles;
        vec_t tbl [4];
        int cyc, beats, bl, bt, bs, bst, nd;
        logic [31:0] fw;
        tbl[0] = '{16'sd12868,  0,      16384};
        tbl[1] = '{16'sd25736,  -16384, 0};
        tbl[2] = '{-16'sd6434,  11585,  -11585};
        tbl[3] = '{16'sd32767,  -10711, -12398};
        foreach (tbl[k]) begin
            send_angle(tbl[k].a);
            wait_first_valid(cyc);
            drain(1'b0, 1'b0, tbl[k].ex, tbl[k].ey, beats, bl, bt, bs, bst, nd, fw);
            compared++;
            if (iabs(xof(fw) - tbl[k].ex) > TOL || iabs(yof(fw) - tbl[k].ey) > TOL) begin
                mismatched++;
                $display("FAIL angle_%0d_vector: got x=%0d y=%0d want x=%0d y=%0d (+-%0d)",
                         tbl[k].a, xof(fw), yof(fw), tbl[k].ex, tbl[k].ey, TOL);
            end
            check_burst($sformatf("angle_%0d", tbl[k].a), beats, bl, bt, bs);
            @(negedge clk_in);
        end
    endtask

    task automatic test_backpressure;
        int cyc, beats, bl, bt, bs, bst, nd, stray;
        logic [31:0] fw;
        send_angle(16'sd0);
        wait_first_valid(cyc);
        drain(1'b1, 1'b1, 16384, 0, beats, bl, bt, bs, bst, nd, fw);
        check_burst("backpressure", beats, bl, bt, bs);
        compared++;
        if (bst != 0) begin
            mismatched++; $display("FAIL stall_stable: got %0d changes under stall want 0", bst);
        end
        stray = 0;
        repeat (25) begin
            @(negedge clk_in);
            if (direction_valid_out !== 1'b0 || angle_ready_out !== 1'b1) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++; $display("FAIL ignored_angle_pulses: got %0d busy cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid_rotate;
        int cyc, beats, bl, bt, bs, bst, nd, stray;
        logic [31:0] fw;
        send_angle(16'sd6434);
        repeat (7) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        compared++;
        if (angle_ready_out !== 1'b1 || direction_valid_out !== 1'b0 || direction_last_out !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_state: got ready/valid/last %b%b%b want 100",
                     angle_ready_out, direction_valid_out, direction_last_out);
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (direction_valid_out !== 1'b0) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++; $display("FAIL abort_no_emit: got %0d valid cycles want 0", stray);
        end
        send_angle(-16'sd6434);
        wait_first_valid(cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++; $display("FAIL abort_restart_latency: got %0d want 17", cyc);
        end
        drain(1'b0, 1'b0, 11585, -11585, beats, bl, bt, bs, bst, nd, fw);
        check_burst("after_abort", beats, bl, bt, bs);
        @(negedge clk_in);
    endtask

    task automatic test_quantity_one;
        int cyc;
        @(negedge clk_in);
        angle1 = -16'sd12868;
        angle_valid1 = 1'b1;
        direction_ready1 = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        angle_valid1 = 1'b0;
        cyc = 0;
        while (!direction_valid1 && cyc < 100) begin
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
        compared++;
        if (cyc != 17 || direction_last1 !== 1'b1) begin
            mismatched++;
            $display("FAIL q1_first_is_last: got cyc=%0d last=%b want cyc=17 last=1", cyc, direction_last1);
        end
        compared++;
        if (iabs(xof(direction1)) > TOL || iabs(yof(direction1) + 16384) > TOL) begin
            mismatched++;
            $display("FAIL q1_vector: got x=%0d y=%0d want x=0 y=-16384 (+-%0d)",
                     xof(direction1), yof(direction1), TOL);
        end
        @(negedge clk_in);
        compared++;
        if (direction_valid1 !== 1'b0 || angle_ready1 !== 1'b1) begin
            mismatched++;
            $display("FAIL q1_single_beat: got valid/ready %b%b want 01", direction_valid1, angle_ready1);
        end
    endtask

    initial begin
        test_reset;
        test_angle_zero;
        test_angles;
        test_backpressure;
        test_reset_mid_rotate;
        test_quantity_one;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
